// File: rtl/lifo_pkg.sv
// Shared definitions for the stack arbiter: op codes, reset stretch length
// and width helpers used by the arbiter top and its round-robin picker.
package lifo_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_SWAP,
    OP_EMPTY_POP
  } op_t;

  // Clocks lifo_reset stays high after the arbiter leaves reset.
  localparam int RST_STRETCH = 2;

  function automatic int count_w(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: lowest eligible index at or after ptr, wrapping.
// Ports: elig/ptr in; one-hot gnt, binary idx and any-grant flag out.
module rr_arbiter
  import lifo_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam int SW = IW + 1;

  logic [N-1:0]  rot;
  logic [SW-1:0] off;
  logic [SW-1:0] sum;

  always_comb begin
    // rotate so bit 0 is the requester at ptr
    rot = N'({elig, elig} >> ptr);
    off = '0;
    any = |elig;
    for (int o = N - 1; o >= 0; o--) begin
      if (rot[o]) off = SW'(o);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= SW'(N)) sum = sum - SW'(N);
    idx = sum[IW-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one stack between NUM_REQ requesters: round-robin push/pop/swap,
// full/empty guarding, pop data routing, stack reset stretch, level mirror.
// Ports:
//   clock, reset            clock and async active-high reset
//   req_push/req_pop/data   per-requester requests (push+pop = swap)
//   gnt                     one-hot combinational accept
//   resp_valid/empty/data   response to the owner, cycle after grant
//   lifo_*                  attached stack interface
//   level, sync_err         occupancy mirror and sticky mismatch flag
module lifo_arbiter
  import lifo_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int LIFO_SIZE = 6,
  parameter int NUM_REQ = 4,
  localparam int COUNT_W = count_w(LIFO_SIZE),
  localparam int IDX_W = idx_w(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_push,
  input  logic [NUM_REQ-1:0]        req_pop,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [NUM_REQ-1:0]        resp_empty,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      lifo_reset,
  output logic                      lifo_write,
  output logic                      lifo_read,
  output logic [DATA_W-1:0]         lifo_datain,
  input  logic [DATA_W-1:0]         lifo_dataout,
  input  logic                      lifo_val,
  input  logic                      lifo_full,
  output logic [COUNT_W-1:0]        level,
  output logic                      sync_err
);

  localparam logic [COUNT_W-1:0] FULL_LVL = COUNT_W'(LIFO_SIZE);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [1:0]         rst_cnt;
  logic [1:0]         rst_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  op_t                op;
  op_t                rsp_op;
  logic [IDX_W-1:0]   rsp_own;
  logic [DATA_W-1:0]  rsp_hold;
  logic               rsp_real;
  logic               err_now;
  logic [NUM_REQ-1:0] own_hot;

  // Stack reset stretch: high in reset and for RST_STRETCH clocks after.
  assign rst_nxt = (rst_cnt != 2'd0) ? rst_cnt - 2'd1 : 2'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_cnt    <= 2'(RST_STRETCH);
      lifo_reset <= 1'b1;
    end else begin
      rst_cnt    <= rst_nxt;
      lifo_reset <= (rst_nxt != 2'd0);
    end
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      unique case ({req_push[i], req_pop[i]})
        2'b10:   elig[i] = (level < FULL_LVL);
        2'b01:   elig[i] = 1'b1;
        2'b11:   elig[i] = (level != '0);
        default: elig[i] = 1'b0;
      endcase
    end
    if (lifo_reset) elig = '0;
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .elig(elig),
    .ptr (rr_ptr),
    .gnt (pick),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign gnt = pick;

  always_comb begin
    op = OP_NONE;
    if (pick_any) begin
      unique case ({req_push[pick_idx], req_pop[pick_idx]})
        2'b10:   op = OP_PUSH;
        2'b11:   op = OP_SWAP;
        default: op = (level != '0) ? OP_POP : OP_EMPTY_POP;
      endcase
    end
  end

  assign lifo_write  = (op == OP_PUSH) || (op == OP_SWAP);
  assign lifo_read   = (op == OP_POP) || (op == OP_SWAP);
  assign lifo_datain = req_data[pick_idx*DATA_W +: DATA_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      level   <= '0;
      rsp_op  <= OP_NONE;
      rsp_own <= '0;
    end else begin
      rsp_op <= op;
      if (pick_any) begin
        rsp_own <= pick_idx;
        rr_ptr  <= (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
      end
      unique case (op)
        OP_PUSH: level <= level + COUNT_W'(1);
        OP_POP:  level <= level - COUNT_W'(1);
        default: ;
      endcase
    end
  end

  // Response side: data comes straight from the stack in the cycle
  // after the read; an empty-pop replays the last returned word.
  assign rsp_real   = (rsp_op == OP_POP) || (rsp_op == OP_SWAP);
  assign own_hot    = NUM_REQ'(1) << rsp_own;
  assign resp_valid = rsp_real ? own_hot : '0;
  assign resp_empty = (rsp_op == OP_EMPTY_POP) ? own_hot : '0;
  assign resp_data  = rsp_real ? lifo_dataout : rsp_hold;

  assign err_now = (rsp_real && !lifo_val) ||
                   (!lifo_reset && (lifo_full != (level == FULL_LVL)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_hold <= '0;
      sync_err <= 1'b0;
    end else begin
      if (rsp_real) rsp_hold <= lifo_dataout;
      if (err_now) sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench for lifo_arbiter: behavioural stack attached, queue-based
// reference model of arbitration, occupancy and response routing.
module tb_lifo_arbiter;

  localparam int DW = 10;
  localparam int SZ = 6;
  localparam int NR = 4;
  localparam int CW = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req_push;
  logic [NR-1:0]     req_pop;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     resp_valid;
  logic [NR-1:0]     resp_empty;
  logic [DW-1:0]     resp_data;
  logic              lifo_reset;
  logic              lifo_write;
  logic              lifo_read;
  logic [DW-1:0]     lifo_datain;
  logic [DW-1:0]     lifo_dataout;
  logic              lifo_val;
  logic              lifo_full;
  logic [CW-1:0]     level;
  logic              sync_err;

  always #5 clock = ~clock;

  lifo_arbiter #(
    .DATA_W(DW),
    .LIFO_SIZE(SZ),
    .NUM_REQ(NR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_push(req_push),
    .req_pop(req_pop),
    .req_data(req_data),
    .gnt(gnt),
    .resp_valid(resp_valid),
    .resp_empty(resp_empty),
    .resp_data(resp_data),
    .lifo_reset(lifo_reset),
    .lifo_write(lifo_write),
    .lifo_read(lifo_read),
    .lifo_datain(lifo_datain),
    .lifo_dataout(lifo_dataout),
    .lifo_val(lifo_val),
    .lifo_full(lifo_full),
    .level(level),
    .sync_err(sync_err)
  );

  // attached stack
  logic [DW-1:0] mem [SZ];
  int            sp;
  logic          sval;
  logic          kill = 1'b0;

  always @(posedge clock) begin
    if (lifo_reset) begin
      sp <= 0;
      sval <= 1'b0;
      lifo_dataout <= '0;
    end else begin
      sval <= 1'b0;
      if (lifo_read && sp > 0) begin
        lifo_dataout <= mem[sp-1];
        sval <= 1'b1;
        if (lifo_write) mem[sp-1] <= lifo_datain;
        else sp <= sp - 1;
      end else if (lifo_write && sp < SZ) begin
        mem[sp] <= lifo_datain;
        sp <= sp + 1;
      end
    end
  end

  assign lifo_val  = sval & ~kill;
  assign lifo_full = (sp == SZ);

  // reference model
  logic [DW-1:0] rq[$];
  int            rptr;
  int            rst_left;
  logic [NR-1:0] e_rv;
  logic [NR-1:0] e_re;
  logic [DW-1:0] e_rd;
  logic [DW-1:0] last_rd;
  bit            rd_known;
  bit            e_err;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    req_push = '0;
    req_pop  = '0;
    req_data = '0;
  endtask

  task automatic set_req(input int i, input bit p, input bit q,
                         input logic [DW-1:0] d);
    clr();
    req_push[i] = p;
    req_pop[i]  = q;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic step(output int k);
    bit ok;
    bit p;
    bit q;
    bit wr;
    bit rd;
    int j;
    logic [DW-1:0] d;
    #1;
    k = -1;
    if (rst_left == 0) begin
      for (int o = 0; o < NR; o++) begin
        j = (rptr + o) % NR;
        p = req_push[j];
        q = req_pop[j];
        ok = (p && !q && rq.size() < SZ) || (!p && q) ||
             (p && q && rq.size() > 0);
        if (ok && k < 0) k = j;
      end
    end
    wr = (k >= 0) && req_push[k];
    rd = (k >= 0) && req_pop[k] && rq.size() > 0;
    d  = (k >= 0) ? req_data[k*DW +: DW] : '0;
    check("lifo_reset", 32'(lifo_reset), 32'(rst_left != 0));
    check("gnt", 32'(gnt), (k >= 0) ? 32'(1) << k : 32'd0);
    check("lifo_write", 32'(lifo_write), 32'(wr));
    check("lifo_read", 32'(lifo_read), 32'(rd));
    if (wr) check("lifo_datain", 32'(lifo_datain), 32'(d));
    check("level", 32'(level), rq.size());
    check("sync_err", 32'(sync_err), 32'(e_err));
    check("resp_valid", 32'(resp_valid), 32'(e_rv));
    check("resp_empty", 32'(resp_empty), 32'(e_re));
    if (e_rv != 0 || (e_re != 0 && rd_known))
      check("resp_data", 32'(resp_data), 32'(e_rd));
    if (e_rv != 0 && kill) e_err = 1'b1;
    e_rv = '0;
    e_re = '0;
    if (rst_left > 0) rst_left--;
    if (k >= 0) begin
      rptr = (k + 1) % NR;
      if (req_push[k] && !req_pop[k]) begin
        rq.push_back(d);
      end else if (rq.size() == 0) begin
        e_re = NR'(1) << k;
        e_rd = last_rd;
      end else begin
        e_rd = rq[rq.size()-1];
        last_rd = e_rd;
        rd_known = 1'b1;
        e_rv = NR'(1) << k;
        if (req_push[k]) rq[rq.size()-1] = d;
        else void'(rq.pop_back());
      end
    end
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("rst_lifo_reset", 32'(lifo_reset), 32'd1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_empty", 32'(resp_empty), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_strobes", {30'd0, lifo_write, lifo_read}, 32'd0);
    reset = 1'b0;
    rq.delete();
    rptr = 0;
    rst_left = 2;
    e_rv = '0;
    e_re = '0;
    e_err = 1'b0;
    rd_known = 1'b0;
    last_rd = '0;
  endtask

  bit            act [NR];
  bit            pp  [NR];
  bit            pq  [NR];
  logic [DW-1:0] pd  [NR];

  initial begin
    int k;
    int kind;
    clr();
    #2;
    req_push = '1;
    apply_reset();
    req_push = '1;
    step(k);
    step(k);
    clr();
    step(k);

    for (int i = 1; i <= 6; i++) begin
      set_req(0, 1, 0, DW'(i));
      step(k);
    end
    set_req(0, 1, 0, 10'h007);
    repeat (3) step(k);
    set_req(0, 0, 1, '0);
    repeat (6) step(k);
    set_req(3, 0, 1, '0);
    step(k);
    clr();
    step(k);

    req_push = '1;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(10'h100 + i);
    repeat (6) step(k);
    set_req(2, 0, 1, '0);
    repeat (6) step(k);
    clr();
    step(k);

    set_req(2, 1, 0, 10'h155);
    step(k);
    set_req(3, 0, 1, '0);
    step(k);
    clr();
    step(k);
    set_req(1, 0, 1, '0);
    step(k);
    clr();
    step(k);

    set_req(0, 1, 0, 10'h00A);
    step(k);
    set_req(0, 1, 1, 10'h0BB);
    step(k);
    clr();
    step(k);
    set_req(0, 0, 1, '0);
    step(k);
    clr();
    step(k);

    for (int i = 0; i < NR; i++) act[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!act[i] && $urandom_range(1, 0) == 1) begin
          kind = $urandom_range(2, 0);
          pp[i] = (kind != 1);
          pq[i] = (kind != 0);
          pd[i] = DW'($urandom_range(1023, 0));
          act[i] = 1'b1;
        end
        req_push[i] = act[i] && pp[i];
        req_pop[i]  = act[i] && pq[i];
        req_data[i*DW +: DW] = pd[i];
      end
      step(k);
      if (k >= 0) act[k] = 1'b0;
    end
    clr();
    step(k);

    set_req(0, 1, 0, 10'h2C3);
    step(k);
    set_req(0, 0, 1, '0);
    step(k);
    clr();
    reset = 1'b1;
    #1;
    check("resp_drop", 32'(resp_valid), 32'd0);
    apply_reset();
    repeat (3) step(k);

    set_req(0, 1, 0, 10'h3A5);
    step(k);
    set_req(0, 0, 1, '0);
    step(k);
    clr();
    kill = 1'b1;
    step(k);
    kill = 1'b0;
    repeat (3) step(k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Shares one stack instance (DATA_W x LIFO_SIZE, write/read/val/full interface) between NUM_REQ requesters.
- Arbitrates push, pop and swap requests round-robin, guards against pushes to a full stack and pops from an empty one, and routes pop data back to the requester that issued the pop.
- Sequences the stack's synchronous reset and keeps an occupancy mirror, because the stack exports no empty flag.

Parameters:
- DATA_W, 10, data word width.
- LIFO_SIZE, 6, depth of the attached stack.
- NUM_REQ, 4, number of requesters (2..8).
- COUNT_W (localparam), $clog2(LIFO_SIZE+1), width of the occupancy count.
- IDX_W (localparam), $clog2(NUM_REQ), width of a requester index.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- req_push  in  NUM_REQ  per-requester push request; level, held until gnt.
- req_pop  in  NUM_REQ  per-requester pop request; push and pop together form a swap request.
- req_data  in  NUM_REQ*DATA_W  push data; slice i belongs to requester i.
- gnt  out  NUM_REQ  one-hot accept; combinational, same cycle as the request.
- resp_valid  out  NUM_REQ  one-cycle pulse to the owner when pop/swap data is on resp_data.
- resp_empty  out  NUM_REQ  one-cycle pulse to the owner when a pop hit an empty stack.
- resp_data  out  DATA_W  returned data; valid only with resp_valid.
- lifo_reset  out  1  drives the stack's synchronous reset.
- lifo_write  out  1  stack write strobe.
- lifo_read  out  1  stack read strobe.
- lifo_datain  out  DATA_W  stack write data.
- lifo_dataout  in  DATA_W  stack read data; arrives one cycle after lifo_read.
- lifo_val  in  1  stack read-valid.
- lifo_full  in  1  stack full flag; checked only.
- level  out  COUNT_W  occupancy mirror.
- sync_err  out  1  sticky mirror/stack mismatch flag.

Behaviour:
- Reset (async) values: level=0, rr_ptr=0, owner state cleared, sync_err=0, lifo_reset=1, all gnt/resp outputs 0.
- lifo_reset stays 1 while reset is high and for 2 clocks after reset deasserts, so the stack sees at least one clean edge with its reset high.
- No grants while lifo_reset=1. lifo_write and lifo_read are 0 then.
- Request classes: op = push (push only), pop (pop only), swap (both).
- Eligibility:
  - push needs level<LIFO_SIZE.
  - swap needs level!=0.
  - pop is always eligible; it is a real pop if level!=0, an empty-pop otherwise.
- Ineligible requests are not granted, stay pending, and are skipped by arbitration.
- Arbitration: at most one grant per cycle. Search the eligible requesters starting at rr_ptr, wrapping modulo NUM_REQ. On a grant to requester k, rr_ptr <= k+1 (mod NUM_REQ); otherwise rr_ptr holds.
- Stack drive, combinational in the grant cycle:
  - push: lifo_write=1, lifo_datain=req_data[k].
  - pop with level!=0: lifo_read=1.
  - swap: both strobes set, lifo_datain=req_data[k].
  - empty-pop: no strobe.
- level update: push +1, real pop -1, swap and empty-pop unchanged. Never wraps.
- Response, cycle after grant: owner index and op are registered at the grant.
  - After a real pop or swap: resp_valid[owner]=1 and resp_data=lifo_dataout, which is the old top. Swap leaves the new datum on top.
  - After an empty-pop: resp_empty[owner]=1 and resp_data holds its previous value.
- Throughput: one operation per cycle. Back-to-back grants are allowed; a response and a new grant can coincide.
- sync_err is set, and held until reset, if either:
  - a real pop/swap response cycle sees lifo_val=0;
  - lifo_full differs from (level==LIFO_SIZE) while lifo_reset=0.
- Reset mid-operation: a pending response is dropped; no resp pulse is issued after reset.

Decomposition:
- Shared package lifo_pkg: op encoding OP_NONE/OP_PUSH/OP_POP/OP_SWAP/OP_EMPTY_POP, reset-stretch length constant (2), and the COUNT_W/IDX_W derivation functions.
- One natural sub-module: rr_arbiter, a parameterised round-robin picker. Inputs: eligible vector and pointer. Outputs: one-hot grant and index. Reusable by other shared-resource blocks.

Test Plan:
- Reset sequencing: assert reset 3 cycles, then release -> lifo_reset high for 2 more cycles; no gnt even with req_push=4'b1111; level=0.
- Fill and overflow guard: requester 0 pushes 0x001..0x006 -> 6 grants, level=6, lifo_full=1. A 7th push is never granted while pending; sync_err=0.
- Round-robin fairness: all 4 requesters request push continuously from rr_ptr=0 -> gnt sequence 0,1,2,3,0,1 over 6 consecutive cycles.
- Response routing: push 0x155 by req 2, then pop by req 3 -> next cycle resp_valid=4'b1000, resp_data=0x155, level=0.
- Empty-pop: req 1 pops with level=0 -> gnt[1]=1, no lifo_read; next cycle resp_empty[1]=1, resp_valid=0.
- Swap and mismatch: stack holds 0x00A; swap by req 0 with 0x0BB -> resp_data=0x00A, level unchanged, a later pop returns 0x0BB. A bench force of lifo_val=0 on a pop response -> sync_err=1 and stays set.
